// File: rtl/aes_inv_key_expansion.sv
// AES-128 inverse key schedule: walks round keys from round 10 down to round 0,
// one key per accepted beat, holding only the current round key.
module aes_inv_key_expansion #(
   parameter int NR         = 10,
   parameter int TEXT_WIDTH = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [TEXT_WIDTH-1:0] last_key_i,
   output logic [TEXT_WIDTH-1:0] rkey_o,
   output logic [3:0]            rkey_round_o,
   output logic                  rkey_valid_o,
   input  logic                  rkey_ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [3:0] LastRound = 4'(NR);

   // Forward AES S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] idx;
      idx = 11'd2047 - {x, 3'b000};
      return SboxTbl[idx -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Rcon of the round being left, not of the round being entered.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   state_e                  state_q;
   logic [TEXT_WIDTH-1:0]   key_q;
   logic [3:0]              round_q;
   logic                    done_q;

   logic [31:0] k0, k1, k2, k3;
   logic [31:0] p0, p1, p2, p3;
   logic [TEXT_WIDTH-1:0]   key_d;

   assign k0 = key_q[127:96];
   assign k1 = key_q[95:64];
   assign k2 = key_q[63:32];
   assign k3 = key_q[31:0];

   // Undo one forward expansion step; p3 is recovered first and feeds RotWord/SubWord.
   assign p3    = k3 ^ k2;
   assign p2    = k2 ^ k1;
   assign p1    = k1 ^ k0;
   assign p0    = k0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(round_q), 24'h0};
   assign key_d = {p0, p1, p2, p3};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  key_q   <= last_key_i;
                  round_q <= LastRound;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (rkey_ready_i) begin
                  if (round_q == 4'd0) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     key_q   <= key_d;
                     round_q <= round_q - 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rkey_o       = key_q;
   assign rkey_round_o = round_q;
   assign rkey_valid_o = (state_q == RUN);
   assign busy_o       = (state_q == RUN);
   assign done_o       = done_q;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed and randomized checks of the inverse AES-128 key schedule against
// an independent forward key expansion model with a computed S-box.
module tb_aes_inv_key_expansion;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic [127:0] last_key_i = '0;
   logic [127:0] rkey_o;
   logic [3:0]   rkey_round_o;
   logic         rkey_valid_o;
   logic         rkey_ready_i = 1'b0;
   logic         busy_o;
   logic         done_o;

   aes_inv_key_expansion #(.NR(10), .TEXT_WIDTH(128)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .last_key_i  (last_key_i),
      .rkey_o      (rkey_o),
      .rkey_round_o(rkey_round_o),
      .rkey_valid_o(rkey_valid_o),
      .rkey_ready_i(rkey_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   tb_sbox  [0:255];
   logic [127:0] exp_rk   [0:10];
   logic [127:0] beat_key [0:10];
   logic [3:0]   beat_round [0:10];
   int           nbeats, nvalid, done_at, stall_err;
   logic         done_seen;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from GF(2^8) inversion plus the affine map.
   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
         end
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         tb_sbox[x] = s;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]}
                ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Called at #1 after a rising edge while IDLE; returns at #1 after the start edge.
   task automatic do_start(input logic [127:0] key);
      last_key_i = key;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i    = 1'b0;
   endtask

   // Drives ready with the given percentage and records accepted beats until done_o.
   task automatic collect(input int pct, input int budget, input int inj_round,
                          input logic [127:0] alt_key);
      logic         prev_stall = 1'b0, injected = 1'b0, rdy;
      logic [127:0] prev_key = '0;
      logic [3:0]   prev_round = '0;
      nbeats = 0; nvalid = 0; done_seen = 1'b0; done_at = -1; stall_err = 0;
      for (int i = 0; i < 11; i++) begin
         beat_key[i]   = 'x;
         beat_round[i] = 'x;
      end
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (done_o) begin
            done_seen = 1'b1;
            done_at   = cyc;
            break;
         end
         if (rkey_valid_o) nvalid++;
         if (prev_stall && (!rkey_valid_o || rkey_o !== prev_key || rkey_round_o !== prev_round))
            stall_err++;
         if (!injected && rkey_valid_o && int'(rkey_round_o) == inj_round) begin
            start_i    = 1'b1;
            last_key_i = alt_key;
            injected   = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         rdy = ($urandom_range(0, 99) < pct);
         rkey_ready_i = rdy;
         if (rkey_valid_o && rdy) begin
            if (nbeats < 11) begin
               beat_key[nbeats]   = rkey_o;
               beat_round[nbeats] = rkey_round_o;
            end
            nbeats++;
         end
         prev_stall = rkey_valid_o && !rdy;
         prev_key   = rkey_o;
         prev_round = rkey_round_o;
         @(posedge clk_i); #1;
      end
      rkey_ready_i = 1'b0;
      start_i      = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (rkey_o !== '0) begin n_fail++; $display("FAIL reset_rkey: got %h, expected 0", rkey_o); end
      n_checks++; if (rkey_round_o !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d, expected 0", rkey_round_o); end
      n_checks++; if (rkey_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rkey_valid_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_o); end
      @(posedge clk_i); #4 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      n_checks++; if (rkey_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b, expected 0", rkey_valid_o); end
   endtask

   task automatic test_fips();
      model_expand(FIPS_R0);
      do_start(FIPS_R10);
      n_checks++; if (rkey_valid_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL fips_first_valid: valid %b busy %b, expected 1 1", rkey_valid_o, busy_o); end
      collect(100, 40, -1, '0);
      n_checks++; if (nbeats !== 11) begin n_fail++; $display("FAIL fips_nbeats: got %0d, expected 11", nbeats); end
      n_checks++; if (nvalid !== 11) begin n_fail++; $display("FAIL fips_valid_cycles: got %0d, expected 11", nvalid); end
      n_checks++; if (done_at !== 11) begin n_fail++; $display("FAIL fips_done_latency: got %0d, expected 11", done_at); end
      n_checks++; if (beat_key[0] !== FIPS_R10) begin n_fail++; $display("FAIL fips_r10: got %h, expected %h", beat_key[0], FIPS_R10); end
      n_checks++; if (beat_key[1] !== FIPS_R9) begin n_fail++; $display("FAIL fips_r9: got %h, expected %h", beat_key[1], FIPS_R9); end
      n_checks++; if (beat_key[9] !== FIPS_R1) begin n_fail++; $display("FAIL fips_r1: got %h, expected %h", beat_key[9], FIPS_R1); end
      n_checks++; if (beat_key[10] !== FIPS_R0) begin n_fail++; $display("FAIL fips_r0: got %h, expected %h", beat_key[10], FIPS_R0); end
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (beat_key[i] !== exp_rk[10-i] || beat_round[i] !== 4'(10-i)) begin
            n_fail++;
            $display("FAIL fips_beat%0d: got r%0d %h, expected r%0d %h", i, beat_round[i], beat_key[i], 10-i, exp_rk[10-i]);
         end
      end
      @(posedge clk_i); #1;
      n_checks++; if (done_o !== 1'b0 || rkey_valid_o !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: done %b valid %b, expected 0 0", done_o, rkey_valid_o); end
   endtask

   task automatic test_backpressure();
      model_expand(FIPS_R0);
      do_start(FIPS_R10);
      collect(30, 600, -1, '0);
      n_checks++; if (nbeats !== 11) begin n_fail++; $display("FAIL bp_nbeats: got %0d, expected 11", nbeats); end
      n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable cycles, expected 0", stall_err); end
      n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b, expected 1", done_seen); end
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (beat_key[i] !== exp_rk[10-i] || beat_round[i] !== 4'(10-i)) begin
            n_fail++;
            $display("FAIL bp_beat%0d: got r%0d %h, expected r%0d %h", i, beat_round[i], beat_key[i], 10-i, exp_rk[10-i]);
         end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_start_busy();
      model_expand(FIPS_R0);
      do_start(FIPS_R10);
      collect(100, 40, 6, ZERO_R10);
      n_checks++; if (nbeats !== 11) begin n_fail++; $display("FAIL busy_nbeats: got %0d, expected 11", nbeats); end
      n_checks++; if (beat_key[10] !== FIPS_R0) begin n_fail++; $display("FAIL busy_r0: got %h, expected %h", beat_key[10], FIPS_R0); end
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (beat_key[i] !== exp_rk[10-i] || beat_round[i] !== 4'(10-i)) begin
            n_fail++;
            $display("FAIL busy_beat%0d: got r%0d %h, expected r%0d %h", i, beat_round[i], beat_key[i], 10-i, exp_rk[10-i]);
         end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_back_to_back();
      do_start(FIPS_R10);
      collect(100, 40, -1, '0);
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b, expected 1", done_o); end
      do_start(FIPS_R10);
      n_checks++;
      if (rkey_valid_o !== 1'b1 || rkey_round_o !== 4'd10 || rkey_o !== FIPS_R10) begin
         n_fail++;
         $display("FAIL b2b_restart: got valid %b r%0d %h, expected valid 1 r10 %h", rkey_valid_o, rkey_round_o, rkey_o, FIPS_R10);
      end
      collect(100, 40, -1, '0);
      n_checks++; if (beat_key[10] !== FIPS_R0 || nbeats !== 11) begin n_fail++; $display("FAIL b2b_r0: got %0d beats last %h, expected 11 beats last %h", nbeats, beat_key[10], FIPS_R0); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_mid_reset();
      logic found = 1'b0;
      do_start(FIPS_R10);
      rkey_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (rkey_round_o == 4'd4) begin
            found = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
      end
      rkey_ready_i = 1'b0;
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_reach_r4: got %b, expected 1", found); end
      #3 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (rkey_o !== '0 || rkey_round_o !== 4'd0 || rkey_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: got %h r%0d v%b b%b d%b, expected all 0", rkey_o, rkey_round_o, rkey_valid_o, busy_o, done_o);
      end
      @(posedge clk_i); @(posedge clk_i); #4 rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i); #1;
         n_checks++; if (rkey_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle%0d: valid %b busy %b, expected 0 0", c, rkey_valid_o, busy_o); end
      end
      do_start(FIPS_R10);
      n_checks++; if (rkey_valid_o !== 1'b1 || rkey_round_o !== 4'd10 || rkey_o !== FIPS_R10) begin n_fail++; $display("FAIL rst_restart: got v%b r%0d %h, expected v1 r10 %h", rkey_valid_o, rkey_round_o, rkey_o, FIPS_R10); end
      collect(100, 40, -1, '0);
      n_checks++; if (beat_key[10] !== FIPS_R0) begin n_fail++; $display("FAIL rst_r0: got %h, expected %h", beat_key[10], FIPS_R0); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_zero_key();
      model_expand('0);
      do_start(ZERO_R10);
      collect(100, 40, -1, '0);
      n_checks++; if (beat_key[10] !== '0) begin n_fail++; $display("FAIL zero_r0: got %h, expected 0", beat_key[10]); end
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (beat_key[i] !== exp_rk[10-i]) begin
            n_fail++;
            $display("FAIL zero_beat%0d: got %h, expected %h", i, beat_key[i], exp_rk[10-i]);
         end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_random_sweep();
      logic [127:0] key;
      for (int k = 0; k < 6; k++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         model_expand(key);
         do_start(exp_rk[10]);
         collect(70, 200, -1, '0);
         n_checks++; if (nbeats !== 11) begin n_fail++; $display("FAIL rnd%0d_nbeats: got %0d, expected 11", k, nbeats); end
         for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (beat_key[i] !== exp_rk[10-i] || beat_round[i] !== 4'(10-i)) begin
               n_fail++;
               $display("FAIL rnd%0d_beat%0d: got r%0d %h, expected r%0d %h", k, i, beat_round[i], beat_key[i], 10-i, exp_rk[10-i]);
            end
         end
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_backpressure();
      test_start_busy();
      test_back_to_back();
      test_mid_reset();
      test_zero_key();
      test_random_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
